gsim_mtx_fetch: RTL
===================

Name: gsim_mtx_fetch

Overview:
- Upstream fetch engine for the Gauss-Seidel solver core.
- For one matrix index, reads the 17 matrix-memory words in a fixed order: b vector first, then rows 15 down to 0.
- Handles the memory request handshake (rreq/rrdy, variable-latency dout_vld) and buffers returned words in a small FIFO.
- Streams the words to the solver over a valid/ready interface, each word tagged with its row index.

Parameters:
- DEPTH, 4, FIFO depth; also the maximum count of outstanding requests plus buffered words (credit limit). Power of two, 2..16.
- WORDS, 17, words per matrix (16 A rows + 1 b). Fixed.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse; begins fetch of matrix i_mtx_idx.
- i_mtx_idx  input  5  matrix index (0..31), sampled when i_start is accepted.
- o_busy  output  1  high from the cycle after start acceptance until the o_done cycle.
- o_done  output  1  one-cycle pulse after the 17th word is popped.
- o_mem_rreq  output  1  read request.
- o_mem_addr  output  10  read address; valid while o_mem_rreq is high.
- i_mem_rrdy  input  1  memory accepts the request this cycle.
- i_mem_dout  input  256  read data.
- i_mem_dout_vld  input  1  read data valid; responses return in request order.
- o_word_vld  output  1  FIFO head valid.
- o_word_data  output  256  FIFO head data.
- o_word_tag  output  5  16 = b vector, 15..0 = A row index.
- o_word_last  output  1  head is the 17th word of the matrix.
- i_word_rdy  input  1  consumer pops the head when o_word_vld and i_word_rdy are both high.

Behaviour:
- Reset values: i_reset asynchronous, active-high; clock i_clk. All outputs 0; state IDLE; all counters, FIFO pointers and credit count cleared. FIFO contents need not be cleared.
- Memory map:
  - Matrix m occupies addresses 17m..17m+16.
  - Word 17m+16 holds b; word 17m+r holds A row r.
  - base = i_mtx_idx*17, computed in 10 bits; maximum address 543, no overflow.
- Issue order: issue k (0..16) uses address base+16-k. Issue 0 is b, then rows 15..0.
- Tag order: output word j gets tag 16-j, so j=0 gives tag 16.
- States:
  - IDLE: i_start -> ISSUE. Latch base; issue_cnt=0, out_cnt=0. o_busy rises the next cycle.
  - ISSUE: o_mem_rreq = (credits < DEPTH). A request is accepted when o_mem_rreq && i_mem_rrdy; then issue_cnt++, outstanding++. After accepting issue 16 -> DRAIN.
  - DRAIN: rreq low. When the pop of the word with out_cnt==16 occurs -> DONE.
  - DONE: o_done=1 and o_busy=0 for one cycle -> IDLE.
- Output timing: o_mem_rreq, o_mem_addr, o_word_* and o_busy/o_done are decoded from registers only; no combinational input-to-output path. o_mem_addr holds while rreq is high and not yet accepted.
- Credits:
  - credits = outstanding + fifo_count.
  - Request acceptance adds 1; a pop removes 1.
  - dout_vld moves a unit from outstanding to fifo_count; credits are unchanged.
  - Simultaneous events net out in the same cycle.
  - A request is never raised when credits == DEPTH, so the FIFO never overflows.
- Data latency: dout_vld in cycle t -> word visible at o_word_vld in cycle t+1. There is no bypass.
- Stray data: dout_vld with outstanding == 0 (e.g. a response after reset) is dropped with no state change.
- Pop on empty FIFO: no effect.
- i_start while not IDLE: ignored.
- Reset mid-operation: returns immediately to IDLE with FIFO empty and credits 0. Later in-flight responses are dropped per the stray-data rule.
- Start after DONE: back-to-back starts are allowed; the i_start pulse is accepted in IDLE only.

Test Plan:
1. Ideal memory: rrdy=1, latency 1, word_rdy=1, i_mtx_idx=2 -> addresses 50,49,...,34 in order; tags 16,15,...,0; last only on tag 0; o_done exactly once, after 17 pops.
2. Stalled consumer: word_rdy=0, DEPTH=4, latency 3 -> exactly 4 requests accepted, then rreq stays low. Release word_rdy -> remaining 13 words delivered with no loss or duplication.
3. Random rrdy, latency 1..5 and word_rdy at 50% each, idx=0 and idx=31 -> address ranges 16..0 and 543..527; data and tag match the memory model; credits never exceed DEPTH.
4. Simultaneous events: in one cycle, request acceptance, dout_vld and pop all occur -> credits and fifo_count remain consistent; checked against the scoreboard.
5. i_start pulsed during ISSUE with a different idx -> ignored; addresses continue from the original base.
6. i_reset asserted in DRAIN with 2 words outstanding, then late dout_vld pulses -> outputs 0, FIFO stays empty. A new start with idx=1 fetches addresses 33..17 correctly.

Source files
------------

// File: rtl/gsim_mtx_fetch_if.sv
// Bundle of the fetch engine's start/status, memory-read and word-stream
// signals. The master side is the fetch engine; the slave side is its
// environment (controller, matrix memory and solver).
interface gsim_mtx_fetch_if #(
  parameter int DATA_W = 256
);
  logic              i_start;
  logic [4:0]        i_mtx_idx;
  logic              o_busy;
  logic              o_done;
  logic              o_mem_rreq;
  logic [9:0]        o_mem_addr;
  logic              i_mem_rrdy;
  logic [DATA_W-1:0] i_mem_dout;
  logic              i_mem_dout_vld;
  logic              o_word_vld;
  logic [DATA_W-1:0] o_word_data;
  logic [4:0]        o_word_tag;
  logic              o_word_last;
  logic              i_word_rdy;

  modport master (
    input  i_start, i_mtx_idx, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_word_rdy,
    output o_busy, o_done, o_mem_rreq, o_mem_addr,
           o_word_vld, o_word_data, o_word_tag, o_word_last
  );

  modport slave (
    output i_start, i_mtx_idx, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_word_rdy,
    input  o_busy, o_done, o_mem_rreq, o_mem_addr,
           o_word_vld, o_word_data, o_word_tag, o_word_last
  );
endinterface

// File: rtl/gsim_mtx_fetch.sv
// Matrix fetch engine for the Gauss-Seidel core: reads b then A rows 15..0
// of one matrix, buffers the returned words in a small FIFO and streams them
// to the solver tagged with their row index. Outstanding requests plus
// buffered words are bounded by DEPTH, so the FIFO can never overflow.
module gsim_mtx_fetch #(
  parameter int DEPTH  = 4,
  parameter int WORDS  = 17,
  parameter int DATA_W = 256
) (
  input logic i_clk,
  input logic i_reset,
  gsim_mtx_fetch_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 2;
  localparam logic [4:0] LAST_IDX = 5'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [9:0]        base;
  logic [4:0]        issue_cnt;
  logic [4:0]        out_cnt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     credits;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_mem [DEPTH];

  logic start_ok, rreq, accept, resp, word_vld, pop;

  // Matrix m starts at word 17m; 31*17+16 = 543 still fits in 10 bits.
  function automatic logic [9:0] mtx_base(input logic [4:0] idx);
    return {5'd0, idx} * 10'd17;
  endfunction

  assign credits  = outstanding + fifo_cnt;
  assign start_ok = (state == IDLE) && bus.i_start;
  assign rreq     = (state == ISSUE) && (credits < CW'(DEPTH));
  assign accept   = rreq && bus.i_mem_rrdy;
  // A response with nothing outstanding is stray (e.g. issued before a reset).
  assign resp     = bus.i_mem_dout_vld && (outstanding != '0);
  assign word_vld = (fifo_cnt != '0);
  assign pop      = word_vld && bus.i_word_rdy;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode: issue all words, then wait for the final pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = ISSUE;
      ISSUE:   if (accept && (issue_cnt == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:   if (pop && (out_cnt == LAST_IDX)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control counters, credit accounting and FIFO pointers; simultaneous
  // accept/response/pop events net out in one update.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      base        <= '0;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (start_ok) begin
        base      <= mtx_base(bus.i_mtx_idx);
        issue_cnt <= '0;
        out_cnt   <= '0;
      end else begin
        if (accept) issue_cnt <= issue_cnt + 5'd1;
        if (pop)    out_cnt   <= out_cnt + 5'd1;
      end
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      fifo_cnt    <= fifo_cnt + CW'(resp) - CW'(pop);
      if (resp) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (resp) fifo_mem[wr_ptr] <= bus.i_mem_dout;
  end

  assign bus.o_busy      = (state == ISSUE) || (state == DRAIN);
  assign bus.o_done      = (state == DONE);
  assign bus.o_mem_rreq  = rreq;
  assign bus.o_mem_addr  = (state == ISSUE) ? (base + 10'd16 - {5'd0, issue_cnt}) : '0;
  assign bus.o_word_vld  = word_vld;
  assign bus.o_word_data = word_vld ? fifo_mem[rd_ptr] : '0;
  assign bus.o_word_tag  = word_vld ? (LAST_IDX - out_cnt) : '0;
  assign bus.o_word_last = word_vld && (out_cnt == LAST_IDX);

endmodule
